sm83_bus_responder: RTL and testbench
=====================================

Name: sm83_bus_responder

Overview:
- Responder end of the sm83 core's memory bus. It decodes `addr`/`write` from the core and returns read data in the same cycle.
- It holds WRAM (with echo), HRAM, the timer block (DIV/TIMA/TMA/TAC), and the interrupt registers IF/IE.
- ROM reads are forwarded to an external ROM port. The block raises `irq` toward the core.

Parameters:
- WRAM_AW, 13, WRAM address width (8 KiB); echo region mirrors with the same width.
- HRAM_DEPTH, 127, HRAM bytes at FF80–FFFE.
- UNMAPPED_VAL, 8'hFF, read value for unmapped addresses.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  16  bus address from core.
- wr_data  in  8  write data from core (core `d_out`).
- write  in  1  write strobe; a write commits at the posedge where it is high.
- rd_data  out  8  read data to core `d_in`; combinational from `addr` and current state.
- rom_addr  out  15  `addr[14:0]`, driven at all times.
- rom_data  in  8  external ROM byte for `rom_addr`.
- irq_in  in  5  one-cycle set pulses for IF bits 4:0 from other sources.
- irq  out  1  registered; equals OR of (IE[4:0] & IF[4:0]).

Behaviour:
- Address map, reads:
  - 0000–7FFF: `rom_data`.
  - C000–DFFF: WRAM[addr[12:0]].
  - E000–FDFF: WRAM[addr[12:0]] (echo).
  - FF04: DIV = div_cnt[15:8].
  - FF05: TIMA.
  - FF06: TMA.
  - FF07: {5'b11111, TAC[2:0]}.
  - FF0F: {3'b111, IF[4:0]}.
  - FF80–FFFE: HRAM[addr-FF80].
  - FFFF: IE.
  - Everything else: UNMAPPED_VAL.
- Writes:
  - ROM and unmapped writes are ignored.
  - FF07 writes store only bits 2:0.
  - FF0F writes store only bits 4:0.
  - FF04 write of any value clears div_cnt to 0 at that edge.
- Read latency is 0 cycles (combinational). A write is visible to reads in the cycle after its edge.
- div_cnt:
  - 16-bit free-running counter, +1 every clk, wraps FFFF→0000.
  - A write to FF04 takes priority over the increment.
- Timer tap by TAC[1:0]: 00 → div_cnt[9], 01 → [3], 10 → [5], 11 → [7].
  - tick = TAC[2] & sel_prev & ~sel_now, a falling edge of the selected bit.
  - sel_prev is registered.
  - A DIV reset that drops the selected bit from 1 to 0 produces a tick.
- TIMA on tick:
  - If TIMA==FF: TIMA←TMA and IF[2]←1 in the same edge (no delay cycle).
  - Otherwise TIMA←TIMA+1.
- Simultaneous events:
  - CPU write to FF05 and tick in the same cycle: the write wins; no overflow is raised.
  - CPU write to FF06 and overflow in the same cycle: reload uses the new TMA value.
  - CPU write to FF0F in the same cycle as an overflow or `irq_in` set: IF ← (wr_data[4:0] | timer_set | irq_in). Sets win over the written clears.
- IF update with no write: IF ← IF | irq_in | {timer_set,2'b00}.
- `irq` is registered from the next-state IE/IF. It asserts one cycle after the IF bit is set.
- Reset (rst low, asynchronous):
  - div_cnt, sel_prev, TIMA, TMA, TAC, IF, IE, and `irq` all go to 0.
  - WRAM and HRAM are not reset; their contents are preserved across reset.
  - `rd_data` remains combinational during reset.
  - Writes are ignored while rst is low.
  - Deasserting reset mid-count restarts div_cnt from 0.

Test Plan:
- Write C123←5A, then read C123 and E123 → both 5A. Read D000 after write to F000=3C → 3C.
- Read 0x1234 with rom_data=A7 → rd_data=A7, rom_addr=1234. Write to 0x1234 → no state change. Read FEA0 → FF.
- TAC=05 (tap bit3), TMA=F0, TIMA=FE → ticks every 16 clks. After 2 ticks TIMA=F0 and IF=04. With IE=04, `irq`=1 one cycle later. Reading FF0F → E4.
- Run 300 clks, write FF04=77 → DIV reads 00 the next cycle. With TAC=06 and div_cnt[5]=1 at the write → exactly one extra TIMA increment.
- Write FF05=10 on the same edge as a TIMA overflow tick → TIMA=10, IF[2] stays 0. Write FF0F=00 with irq_in=01 on the same edge → IF=01.
- Assert rst mid-operation with IE=1F, IF=1F, HRAM[FF80]=99 → `irq`=0 immediately (asynchronous). After release, FF0F reads E0, FFFF reads 00, FF80 still 99.

Source files
------------

// File: rtl/sm83_bus_responder.sv
// sm83 memory-bus responder: WRAM/echo, HRAM, timer, IF/IE and ROM pass-through.
// Reads are combinational; all state commits on the rising clock edge.
module sm83_bus_responder #(
    parameter int         WRAM_AW      = 13,
    parameter int         HRAM_DEPTH   = 127,
    parameter logic [7:0] UNMAPPED_VAL = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wr_data,
    input  logic        write,
    output logic [7:0]  rd_data,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic [4:0]  irq_in,
    output logic        irq
);

    logic [7:0]  r_wram [2**WRAM_AW];
    logic [7:0]  r_hram [HRAM_DEPTH];

    logic [15:0] r_div;
    logic        r_sel_prev;
    logic [7:0]  r_tima;
    logic [7:0]  r_tma;
    logic [2:0]  r_tac;
    logic [4:0]  r_if;
    logic [7:0]  r_ie;
    logic        r_irq;

    logic        w_sel_rom;
    logic        w_sel_wram;
    logic        w_sel_hram;
    logic        w_sel_ff04;
    logic        w_sel_ff05;
    logic        w_sel_ff06;
    logic        w_sel_ff07;
    logic        w_sel_ff0f;
    logic        w_sel_ie;

    logic        w_sel_now;
    logic        w_tick;
    logic        w_timer_set;
    logic [15:0] w_div_nxt;
    logic [7:0]  w_tima_nxt;
    logic [7:0]  w_tma_nxt;
    logic [2:0]  w_tac_nxt;
    logic [4:0]  w_if_nxt;
    logic [7:0]  w_ie_nxt;

    assign rom_addr   = addr[14:0];
    assign irq        = r_irq;

    assign w_sel_rom  = ~addr[15];
    assign w_sel_wram = (addr[15:13] == 3'b110) ||
                        ((addr[15:13] == 3'b111) && (addr < 16'hFE00));
    assign w_sel_hram = (addr[15:7] == 9'h1FF) && (addr[6:0] != 7'h7F);
    assign w_sel_ff04 = (addr == 16'hFF04);
    assign w_sel_ff05 = (addr == 16'hFF05);
    assign w_sel_ff06 = (addr == 16'hFF06);
    assign w_sel_ff07 = (addr == 16'hFF07);
    assign w_sel_ff0f = (addr == 16'hFF0F);
    assign w_sel_ie   = (addr == 16'hFFFF);

    always_comb begin
        rd_data = UNMAPPED_VAL;
        unique case (1'b1)
            w_sel_rom:  rd_data = rom_data;
            w_sel_wram: rd_data = r_wram[addr[WRAM_AW-1:0]];
            w_sel_ff04: rd_data = r_div[15:8];
            w_sel_ff05: rd_data = r_tima;
            w_sel_ff06: rd_data = r_tma;
            w_sel_ff07: rd_data = {5'b11111, r_tac};
            w_sel_ff0f: rd_data = {3'b111, r_if};
            w_sel_hram: rd_data = r_hram[addr[6:0]];
            w_sel_ie:   rd_data = r_ie;
            default:    rd_data = UNMAPPED_VAL;
        endcase
    end

    always_comb begin
        w_sel_now = 1'b0;
        case (r_tac[1:0])
            2'b00:   w_sel_now = r_div[9];
            2'b01:   w_sel_now = r_div[3];
            2'b10:   w_sel_now = r_div[5];
            default: w_sel_now = r_div[7];
        endcase
    end

    // Falling edge of the tapped bit, including one caused by a DIV clear.
    assign w_tick = r_tac[2] & r_sel_prev & ~w_sel_now;

    always_comb begin
        w_div_nxt   = r_div + 16'd1;
        w_tma_nxt   = r_tma;
        w_tac_nxt   = r_tac;
        w_ie_nxt    = r_ie;
        w_tima_nxt  = r_tima;
        w_timer_set = 1'b0;
        if (write && w_sel_ff04) w_div_nxt = '0;
        if (write && w_sel_ff06) w_tma_nxt = wr_data;
        if (write && w_sel_ff07) w_tac_nxt = wr_data[2:0];
        if (write && w_sel_ie)   w_ie_nxt  = wr_data;
        if (write && w_sel_ff05) begin
            w_tima_nxt = wr_data;
        end else if (w_tick) begin
            if (r_tima == 8'hFF) begin
                w_tima_nxt  = w_tma_nxt;
                w_timer_set = 1'b1;
            end else begin
                w_tima_nxt = r_tima + 8'd1;
            end
        end
        // Set sources always win over bits cleared by a CPU write.
        w_if_nxt = (write && w_sel_ff0f) ? wr_data[4:0] : r_if;
        w_if_nxt = w_if_nxt | irq_in | {2'b00, w_timer_set, 2'b00};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div      <= '0;
            r_sel_prev <= 1'b0;
            r_tima     <= '0;
            r_tma      <= '0;
            r_tac      <= '0;
            r_if       <= '0;
            r_ie       <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_div      <= w_div_nxt;
            r_sel_prev <= w_sel_now;
            r_tima     <= w_tima_nxt;
            r_tma      <= w_tma_nxt;
            r_tac      <= w_tac_nxt;
            r_if       <= w_if_nxt;
            r_ie       <= w_ie_nxt;
            r_irq      <= |(w_ie_nxt[4:0] & w_if_nxt);
        end
    end

    // RAM contents survive reset, but writes are blocked while it is held.
    always_ff @(posedge clk) begin
        if (rst && write && w_sel_wram)
            r_wram[addr[WRAM_AW-1:0]] <= wr_data;
        if (rst && write && w_sel_hram)
            r_hram[addr[6:0]] <= wr_data;
    end

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Scoreboard bench for sm83_bus_responder: directed scenarios plus random
// traffic, all checked against a behavioural model of the bus map and timer.
module tb_sm83_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wr_data = '0;
    logic        write = 1'b0;
    logic [7:0]  rd_data;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic [4:0]  irq_in = '0;
    logic        irq;

    always #5 clk = ~clk;

    sm83_bus_responder dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wr_data  (wr_data),
        .write    (write),
        .rd_data  (rd_data),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .irq_in   (irq_in),
        .irq      (irq)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  rd;
        bit          rd_vld;
        logic        irq;
        logic [14:0] ra;
    } exp_t;

    exp_t sbq[$];

    logic [7:0] m_wram [8192];
    bit         m_wv   [8192];
    logic [7:0] m_hram [128];
    bit         m_hv   [128];
    int m_div, m_tima, m_tma, m_tac, m_if, m_ie;
    bit m_prev, m_irq;

    function automatic int tap_of(int tac);
        case (tac & 3)
            0:       return 9;
            1:       return 3;
            2:       return 5;
            default: return 7;
        endcase
    endfunction

    function automatic bit m_tick();
        return ((m_tac >> 2) & 1) == 1 && m_prev &&
               ((m_div >> tap_of(m_tac)) & 1) == 0;
    endfunction

    function automatic void m_reset();
        m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0;
        m_if = 0; m_ie = 0; m_prev = 0; m_irq = 0;
    endfunction

    function automatic exp_t predict(logic [15:0] a, logic [7:0] rom);
        exp_t e;
        int   idx;
        e.a = a; e.rd_vld = 1; e.irq = m_irq; e.ra = a[14:0];
        if (a < 16'h8000) e.rd = rom;
        else if (a >= 16'hC000 && a < 16'hFE00) begin
            idx = a & 16'h1FFF;
            e.rd = m_wram[idx];
            e.rd_vld = m_wv[idx];
        end
        else if (a == 16'hFF04) e.rd = 8'((m_div >> 8) & 255);
        else if (a == 16'hFF05) e.rd = 8'(m_tima);
        else if (a == 16'hFF06) e.rd = 8'(m_tma);
        else if (a == 16'hFF07) e.rd = 8'(248 + m_tac);
        else if (a == 16'hFF0F) e.rd = 8'(224 + m_if);
        else if (a >= 16'hFF80 && a <= 16'hFFFE) begin
            idx = a - 16'hFF80;
            e.rd = m_hram[idx];
            e.rd_vld = m_hv[idx];
        end
        else if (a == 16'hFFFF) e.rd = 8'(m_ie);
        else e.rd = 8'hFF;
        return e;
    endfunction

    function automatic void m_step(int a, bit w, int d, int ii);
        int bit_now, tma_n, tima_n, if_n;
        bit tick, ts;
        bit_now = (m_div >> tap_of(m_tac)) & 1;
        tick    = m_tick();
        tma_n   = (w && a == 16'hFF06) ? d : m_tma;
        tima_n  = m_tima;
        ts      = 0;
        if (w && a == 16'hFF05) tima_n = d;
        else if (tick) begin
            if (m_tima == 255) begin
                tima_n = tma_n;
                ts = 1;
            end else tima_n = m_tima + 1;
        end
        if_n = (w && a == 16'hFF0F) ? (d & 31) : m_if;
        if_n = if_n | ii | (ts ? 4 : 0);
        m_div  = (w && a == 16'hFF04) ? 0 : ((m_div + 1) & 16'hFFFF);
        m_prev = bit_now[0];
        m_tma  = tma_n;
        m_tima = tima_n;
        m_if   = if_n;
        if (w && a == 16'hFF07) m_tac = d & 7;
        if (w && a == 16'hFFFF) m_ie = d;
        if (w && a >= 16'hC000 && a < 16'hFE00) begin
            m_wram[a & 16'h1FFF] = 8'(d);
            m_wv[a & 16'h1FFF] = 1;
        end
        if (w && a >= 16'hFF80 && a <= 16'hFFFE) begin
            m_hram[a - 16'hFF80] = 8'(d);
            m_hv[a - 16'hFF80] = 1;
        end
        m_irq = (m_ie & m_if & 31) != 0;
    endfunction

    // Called just after a posedge; returns just after the next posedge.
    task automatic cyc(input logic [15:0] a, input bit w,
                       input logic [7:0] d, input logic [4:0] ii);
        logic [7:0] rom;
        rom = 8'($urandom);
        addr = a; write = w; wr_data = d; irq_in = ii; rom_data = rom;
        sbq.push_back(predict(a, rom));
        @(posedge clk);
        if (rst) m_step(int'(a), w, int'(d), int'(ii));
        #1;
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(a, 1'b0, 8'h00, 5'h00);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(a, 1'b1, d, 5'h00);
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            if (me.rd_vld) begin
                checks++;
                if (rd_data !== me.rd) begin
                    errors++;
                    $display("FAIL rd_data addr=%h got %h want %h", me.a, rd_data, me.rd);
                end
            end
            checks++;
            if (irq !== me.irq) begin
                errors++;
                $display("FAIL irq addr=%h got %b want %b", me.a, irq, me.irq);
            end
            checks++;
            if (rom_addr !== me.ra) begin
                errors++;
                $display("FAIL rom_addr got %h want %h", rom_addr, me.ra);
            end
        end
    end

    logic [15:0] ra;
    int          sel;
    bit          found;

    initial begin
        m_reset();
        for (int i = 0; i < 8192; i++) m_wv[i] = 0;
        for (int i = 0; i < 128; i++) m_hv[i] = 0;
        @(posedge clk); #1;
        rd(16'hFF0F);
        rd(16'hFF04);
        rst = 1'b1;

        wr(16'hC123, 8'h5A);
        rd(16'hC123);
        rd(16'hE123);
        wr(16'hF000, 8'h3C);
        rd(16'hD000);

        rd(16'h1234);
        wr(16'h1234, 8'h55);
        rd(16'hFEA0);
        wr(16'hFEA0, 8'h00);
        rd(16'hFEA0);

        wr(16'hFF07, 8'h00);
        wr(16'hFF06, 8'hF0);
        wr(16'hFF05, 8'hFE);
        wr(16'hFFFF, 8'h04);
        wr(16'hFF0F, 8'h00);
        wr(16'hFF07, 8'h05);
        repeat (40) rd(16'hFF05);
        rd(16'hFF0F);

        wr(16'hFF07, 8'h06);
        repeat (300) rd(16'hFF04);
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (((m_div >> 5) & 1) == 1) found = 1;
            else rd(16'hFF05);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL div_bit5_wait got timeout want bit5 set");
        end
        wr(16'hFF04, 8'h77);
        rd(16'hFF04);
        repeat (4) rd(16'hFF05);

        wr(16'hFF07, 8'h05);
        wr(16'hFF0F, 8'h00);
        wr(16'hFF05, 8'hFF);
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_tick()) found = 1;
            else rd(16'hFF05);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL tick_wait got timeout want tick");
        end
        wr(16'hFF05, 8'h10);
        rd(16'hFF05);
        rd(16'hFF0F);

        wr(16'hFF07, 8'h00);
        wr(16'hFF0F, 8'h00);
        cyc(16'hFF0F, 1'b1, 8'h00, 5'h01);
        rd(16'hFF0F);

        wr(16'hFFFF, 8'h1F);
        wr(16'hFF0F, 8'h1F);
        wr(16'hFF80, 8'h99);
        rd(16'hFF0F);
        rst = 1'b0;
        m_reset();
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_irq got %b want 0", irq);
        end
        cyc(16'hFF80, 1'b1, 8'h11, 5'h1F);
        cyc(16'hFFFF, 1'b1, 8'h1F, 5'h00);
        rd(16'hFF0F);
        rst = 1'b1;
        rd(16'hFF0F);
        rd(16'hFFFF);
        rd(16'hFF80);
        rd(16'hFF04);

        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: ra = 16'($urandom_range(0, 16'h7FFF));
                1: ra = 16'hC000 | 16'($urandom_range(0, 63)) | ($urandom_range(0, 1) ? 16'h1000 : 16'h0);
                2: ra = 16'hE000 | 16'($urandom_range(0, 63)) | ($urandom_range(0, 1) ? 16'h1000 : 16'h0);
                3: ra = 16'hFF04 + 16'($urandom_range(0, 3));
                4: ra = 16'hFF05;
                5: ra = 16'hFF0F;
                6: ra = 16'hFF80 + 16'($urandom_range(0, 126));
                7: ra = 16'hFFFF;
                8: ra = 16'hFF07;
                default: begin
                    case ($urandom_range(0, 5))
                        0: ra = 16'hFEA0;
                        1: ra = 16'hFF00;
                        2: ra = 16'hFF40;
                        3: ra = 16'hFF7F;
                        4: ra = 16'hA000;
                        default: ra = 16'h8000;
                    endcase
                end
            endcase
            if (ra == 16'hFF04 && $urandom_range(0, 3) != 0)
                cyc(ra, 1'b0, 8'h00, 5'h00);
            else
                cyc(ra, $urandom_range(0, 9) < 3, 8'($urandom),
                    ($urandom_range(0, 19) == 0) ? 5'($urandom) : 5'h00);
        end

        write = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
